// File: rtl/serial_tx_defs.sv
// Shared state encodings and defaults for the serial pattern transmitter.
package serial_tx_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_t;

   localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_shift_reg.sv
// Loadable pattern shift register; exposes the head bit the register will hold after this edge.
// MSB-first patterns shorter than WIDTH are left-justified so the head is always bit WIDTH-1.
module tx_shift_reg #(
   parameter int WIDTH     = 8,
   parameter int LENW      = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   input  logic [LENW-1:0]  i_len,
   output logic             o_bit_nxt
);

   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_sreg_nxt;
   logic [WIDTH-1:0] w_just;

   assign w_just = MSB_FIRST ? (i_data << (WIDTH - int'(i_len))) : i_data;

   always_comb begin
      w_sreg_nxt = r_sreg;
      if (i_load) begin
         w_sreg_nxt = w_just;
      end else if (i_shift) begin
         w_sreg_nxt = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
      end
   end

   assign o_bit_nxt = MSB_FIRST ? w_sreg_nxt[WIDTH-1] : w_sreg_nxt[0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sreg <= '0;
      end else begin
         r_sreg <= w_sreg_nxt;
      end
   end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accept edge N -> first bit in N+1, last bit in N+L, then GAP_CYCLES idle.
// load_ready is high in IDLE, and also on the last bit when GAP_CYCLES=0 for back-to-back frames.
module serial_pattern_tx
   import serial_tx_defs::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   LENW       = 4,
   parameter int   GAP_CYCLES = 1,
   parameter logic IDLE_BIT   = DEF_IDLE_BIT,
   parameter bit   MSB_FIRST  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LENW-1:0]  load_len,
   output logic             x,
   output logic             x_valid,
   output logic             x_last,
   output logic             busy
);

   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   tx_state_t         r_state;
   tx_state_t         w_state_nxt;
   logic [LENW-1:0]   r_cnt;
   logic [LENW-1:0]   w_cnt_nxt;
   logic [GW-1:0]     r_gap;
   logic [GW-1:0]     w_gap_nxt;
   logic [LENW-1:0]   w_len_eff;
   logic              w_len_ok;
   logic              w_accept;
   logic              w_load;
   logic              w_shift;
   logic              w_bit_nxt;
   logic              w_x_nxt;
   logic              w_x_valid_nxt;
   logic              w_x_last_nxt;
   logic              w_busy_nxt;
   logic              w_ready_nxt;

   assign w_len_eff = (load_len > LENW'(WIDTH)) ? LENW'(WIDTH) : load_len;
   assign w_len_ok  = (w_len_eff != '0);
   assign w_accept  = load_valid && load_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Zero-length offers are consumed here without leaving IDLE.
            if (w_accept && w_len_ok) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_nxt   = w_len_eff;
               w_load      = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == LENW'(1)) begin
               if (GAP_CYCLES == 0 && w_accept && w_len_ok) begin
                  w_cnt_nxt = w_len_eff;
                  w_load    = 1'b1;
               end else if (GAP_CYCLES > 0) begin
                  w_state_nxt = ST_GAP;
                  w_gap_nxt   = GW'(GAP_CYCLES);
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_shift   = 1'b1;
               w_cnt_nxt = r_cnt - LENW'(1);
            end
         end
         ST_GAP: begin
            if (r_gap <= GW'(1)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_nxt = r_gap - GW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_x_valid_nxt = (w_state_nxt == ST_SHIFT);
      w_x_last_nxt  = w_x_valid_nxt && (w_cnt_nxt == LENW'(1));
      w_x_nxt       = w_x_valid_nxt ? w_bit_nxt : IDLE_BIT;
      w_busy_nxt    = (w_state_nxt != ST_IDLE);
      w_ready_nxt   = (w_state_nxt == ST_IDLE) || (GAP_CYCLES == 0 && w_x_last_nxt);
   end

   tx_shift_reg #(
      .WIDTH     (WIDTH),
      .LENW      (LENW),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_load    (w_load),
      .i_shift   (w_shift),
      .i_data    (load_data),
      .i_len     (w_len_eff),
      .o_bit_nxt (w_bit_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_gap      <= '0;
         x          <= IDLE_BIT;
         x_valid    <= 1'b0;
         x_last     <= 1'b0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_gap      <= w_gap_nxt;
         x          <= w_x_nxt;
         x_valid    <= w_x_valid_nxt;
         x_last     <= w_x_last_nxt;
         busy       <= w_busy_nxt;
         load_ready <= w_ready_nxt;
      end
   end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter that drives the one-bit `x` input of the homework sequence-detector FSMs. It accepts a parallel pattern word and bit length through a valid/ready handshake and shifts the pattern out one bit per clock. It marks valid bits, flags the last bit, and inserts a programmable idle gap between frames. It sits on the transmit side of the `x` line in the testbench and top-level harnesses, feeding the behavioural and structural FSM receivers.

## Interface
- `WIDTH`, 8: maximum pattern length in bits; also the `load_data` width.
- `LENW`, 4: width of `load_len`; must satisfy `2**LENW > WIDTH`.
- `GAP_CYCLES`, 1: idle cycles inserted after each frame; 0 allowed.
- `IDLE_BIT`, 1'b0: level driven on `x` when no frame is active.
- `MSB_FIRST`, 0: 0 shifts `load_data[0]` first; 1 shifts `load_data[len-1]` first.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_valid`  in  1  a pattern is offered.
- `load_ready`  out  1  the block can accept a pattern this cycle.
- `load_data`  in  WIDTH  pattern bits.
- `load_len`  in  LENW  number of bits to send (0..2**LENW-1).
- `x`  out  1  serial line to the FSM under test.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `x_last`  out  1  the current bit is the final bit of the frame.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, SHIFT, GAP.
- All outputs are registered.
- Reset values: state IDLE, `x`=`IDLE_BIT`, `x_valid`=0, `x_last`=0, `busy`=0, `load_ready`=1, bit counter 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). No `x_last` is produced for the aborted frame.
- Accept condition: `load_valid && load_ready` at a rising edge.
- `load_len` is clamped to WIDTH if greater.
- `load_len` 0: the pattern is accepted and discarded; the state stays IDLE and no bits are driven.
- IDLE→SHIFT on accept with effective length L≥1:
  - latch the pattern; set the counter to L;
  - `x` is the first bit and `x_valid`=1 in the cycle after the accept edge.
- SHIFT: one bit per cycle; the counter decrements. `x_last`=1 on the bit where the counter equals 1.
- SHIFT→GAP after the last bit when `GAP_CYCLES`>0. GAP holds `x`=`IDLE_BIT` and `x_valid`=0 for exactly `GAP_CYCLES` cycles, then goes to IDLE.
- SHIFT→IDLE after the last bit when `GAP_CYCLES`=0.
- `load_ready`=1 in IDLE.
- When `GAP_CYCLES`=0, `load_ready` is also 1 during the last-bit SHIFT cycle. An accept on that edge goes SHIFT→SHIFT, so consecutive frames are back-to-back with no idle bit.
- `load_data` and `load_len` are ignored whenever `load_ready`=0.
- `busy`=1 in SHIFT and GAP.

## Timing
- Latency: accept edge N → first bit valid in cycle N+1 → last bit in cycle N+L.
- Gap: cycles N+L+1 .. N+L+`GAP_CYCLES`. `load_ready` rises in cycle N+L+`GAP_CYCLES`+1.
- Frame period: L+`GAP_CYCLES`+1 cycles minimum when `GAP_CYCLES`>0; L when `GAP_CYCLES`=0.
- `x` changes only on rising edges, so the receiver samples it on the following edge.

## Structure
- Shared package/include `serial_tx_defs`:
  - 2-bit state encodings `ST_IDLE`=0, `ST_SHIFT`=1, `ST_GAP`=2;
  - default `IDLE_BIT`.
- Sub-module `tx_shift_reg`:
  - WIDTH-bit loadable shift register with direction select (`MSB_FIRST`) and a left-justify on load for MSB-first with L<WIDTH;
  - outputs the current bit.
- The top module holds the FSM, bit counter and gap counter.

## Test plan
- Reset, then idle 5 cycles → `x`=0, `x_valid`=0, `load_ready`=1, `busy`=0.
- Load `load_data`=8'b1011_0010, `load_len`=8, LSB-first → `x` = 0,1,0,0,1,1,0,1 over cycles N+1..N+8; `x_last` only at N+8; `load_ready` returns at N+10 (`GAP_CYCLES`=1).
- MSB-first, `load_data`=8'h05, `load_len`=3 → `x` = 1,0,1; `load_len`=12 is clamped to 8 bits sent.
- `GAP_CYCLES`=0, `load_valid` held high with frames 8'h0F/len 4 then 8'h03/len 2 → 6 contiguous valid bits 1,1,1,1,1,1 with no gap.
- `load_len`=0 offered → accepted, `busy` stays 0, `x_valid` never rises.
- Assert `rst` at the 3rd bit of an 8-bit frame → outputs return to reset values within the same cycle; no `x_last`; the next load transmits normally.
